// File: rtl/ysyx_2022040010_div.sv
// Iterative radix-2 restoring divider for the RV64 EXU (DIV/DIVU/REM/REMU and W forms).
// Quotient and remainder come out together; one quotient bit is produced per CALC cycle.
module ysyx_2022040010_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            div_signed,
    input  logic            div_32,
    input  logic [XLEN-1:0] div_a,
    input  logic [XLEN-1:0] div_b,
    input  logic            flush,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [64:0] rem_r;
    logic [63:0] quo_r, dvs_r, q_hold_r, r_hold_r;
    logic [5:0]  cnt_r;
    logic        w_r, neg_q_r, neg_r_r;

    logic [63:0] wmask_s, a_sel_s, b_sel_s, a_mag_s, b_mag_s;
    logic        a_neg_s, b_neg_s, dz_s, ovf_s, special_s, accept_s;
    logic [65:0] shift_s, diff_s;
    logic        ge_s;
    logic [64:0] rem_nx_s;
    logic [63:0] q_raw_s, q_sgn_s, q_fin_s, r_sgn_s, r_fin_s;

    // Operand preparation: width select, sign capture, magnitudes and special-case detection.
    always_comb begin
        wmask_s   = div_32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        a_sel_s   = div_a & wmask_s;
        b_sel_s   = div_b & wmask_s;
        a_neg_s   = div_signed & (div_32 ? div_a[31] : div_a[63]);
        b_neg_s   = div_signed & (div_32 ? div_b[31] : div_b[63]);
        a_mag_s   = (a_neg_s ? (64'd0 - a_sel_s) : a_sel_s) & wmask_s;
        b_mag_s   = (b_neg_s ? (64'd0 - b_sel_s) : b_sel_s) & wmask_s;
        dz_s      = (b_sel_s == 64'd0);
        if (div_32) begin
            ovf_s = div_signed & (div_a[31:0] == 32'h8000_0000) & (div_b[31:0] == 32'hFFFF_FFFF);
        end else begin
            ovf_s = div_signed & (div_a == 64'h8000_0000_0000_0000) & (div_b == 64'hFFFF_FFFF_FFFF_FFFF);
        end
        special_s = dz_s | ovf_s;
        accept_s  = div_valid & (state_r == IDLE) & ~flush;
    end

    // One restoring step; the remainder never reaches the divisor, so the top bits stay clear.
    always_comb begin
        shift_s  = {rem_r, quo_r[63]};
        diff_s   = shift_s - {2'b00, dvs_r};
        ge_s     = ~diff_s[65];
        rem_nx_s = ge_s ? diff_s[64:0] : shift_s[64:0];
    end

    // Sign fix-up and W-form sign extension of the finished magnitudes.
    always_comb begin
        q_raw_s = w_r ? {32'd0, quo_r[31:0]} : quo_r;
        q_sgn_s = neg_q_r ? (64'd0 - q_raw_s) : q_raw_s;
        r_sgn_s = neg_r_r ? (64'd0 - rem_r[63:0]) : rem_r[63:0];
        if (w_r) begin
            q_fin_s = {{32{q_sgn_s[31]}}, q_sgn_s[31:0]};
            r_fin_s = {{32{r_sgn_s[31]}}, r_sgn_s[31:0]};
        end else begin
            q_fin_s = q_sgn_s;
            r_fin_s = r_sgn_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = special_s ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_s = IDLE;
                end else if (cnt_r == 6'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: load on accept, iterate in CALC, commit held results in DONE unless flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r    <= 65'd0;
            quo_r    <= 64'd0;
            dvs_r    <= 64'd0;
            cnt_r    <= 6'd0;
            w_r      <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            q_hold_r <= 64'd0;
            r_hold_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        w_r <= div_32;
                        if (special_s) begin
                            // Special results skip the sign fix; only W extension applies.
                            quo_r   <= dz_s ? 64'hFFFF_FFFF_FFFF_FFFF : a_sel_s;
                            rem_r   <= dz_s ? {1'b0, a_sel_s} : 65'd0;
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                        end else begin
                            quo_r   <= div_32 ? {a_mag_s[31:0], 32'd0} : a_mag_s;
                            rem_r   <= 65'd0;
                            dvs_r   <= b_mag_s;
                            cnt_r   <= div_32 ? 6'd31 : 6'd63;
                            neg_q_r <= a_neg_s ^ b_neg_s;
                            neg_r_r <= a_neg_s;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_nx_s;
                    quo_r <= {quo_r[62:0], ge_s};
                    cnt_r <= cnt_r - 6'd1;
                end
                DONE: begin
                    if (!flush) begin
                        q_hold_r <= q_fin_s;
                        r_hold_r <= r_fin_s;
                    end
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    // Output decode: results are live in DONE and held afterwards.
    always_comb begin
        div_ready = 1'b0;
        out_valid = 1'b0;
        quotient  = q_hold_r;
        remainder = r_hold_r;
        if (state_r == DONE) begin
            out_valid = ~flush;
            quotient  = q_fin_s;
            remainder = r_fin_s;
        end else begin
            div_ready = (state_r == IDLE);
        end
    end

endmodule

// File: doc/ysyx_2022040010_div.md
Name: ysyx_2022040010_div

Overview:
Iterative radix-2 restoring divider for the RV64 EXU, the subtract-and-shift counterpart to the single-cycle adder. It implements DIV/DIVU/REM/REMU and the W variants (DIVW/DIVUW/REMW/REMUW). Quotient and remainder are produced together in one pass. It sits beside the ALU and handshakes with the EXU stall logic.

Parameters:
XLEN, 64, full datapath width; only 64 is supported.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
div_valid  in  1  request; operands sampled when div_valid && div_ready
div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
div_32  in  1  1 = W variant: use in_a[31:0]/in_b[31:0] only
div_a  in  64  dividend
div_b  in  64  divisor
flush  in  1  abort the current operation (pipeline redirect)
div_ready  out  1  high only in IDLE
out_valid  out  1  one-cycle result strobe
quotient  out  64  result quotient
remainder  out  64  result remainder

Behaviour:
- Reset (async, rst=1): state=IDLE, div_ready=1, out_valid=0, quotient=0, remainder=0, internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on accept, where accept = div_valid && div_ready in cycle T.
- IDLE -> DONE on accept when a special case applies.
- CALC -> DONE after N iterations; N=32 if div_32, else 64.
- DONE -> IDLE unconditionally after one cycle.
- Latency, normal case: CALC occupies cycles T+1..T+N. out_valid is high in cycle T+N+1 (DONE). div_ready is high again in T+N+2.
- Latency, special case: out_valid is high in cycle T+1.
- Operand prep at accept: in 32-bit mode, take the low 32 bits of each operand. If signed, record each operand's sign and take its magnitude (two's-complement negate when negative). Unsigned operands are zero-extended.
- Iteration: each step shifts {rem, quo} left by 1 and computes the trial rem - divisor with a (XLEN+1)-bit subtract. If the result is non-negative, rem takes the result and the quo LSB is 1; otherwise rem is kept and the quo LSB is 0.
- Sign fix in DONE:
  - quotient is negated if signed and sign(a) != sign(b);
  - remainder is negated if signed and sign(a) is negative (the remainder carries the dividend's sign).
- W results: both outputs are sign-extended from bit 31, including DIVUW/REMUW.
- Divide by zero (divisor = 0 within the active width): quotient = all ones (then sign-extended if W), remainder = dividend (W: sign-extended low 32 bits). No trap.
- Signed overflow (dividend is the most negative value and divisor is -1, for the active width): quotient = dividend, remainder = 0.
- If both divide-by-zero and overflow conditions would apply, divide-by-zero takes precedence.
- Output hold: quotient and remainder hold their values from DONE until the next result is written. out_valid is a single-cycle pulse, never held.
- flush:
  - In CALC or DONE: next state is IDLE, out_valid is forced 0 that cycle, and the result registers are not updated.
  - In IDLE: flush is ignored unless div_valid is also high. If both are high, flush wins: no accept, div_ready stays 1.
- div_valid outside IDLE is ignored; the requester must hold the request until it is accepted.
- rst asserted mid-CALC returns the block immediately to the reset state above.

Test Plan:
- DIVU: a=100, b=7, div_32=0 -> out_valid exactly at T+65; quotient=14, remainder=2; div_ready=1 at T+66.
- DIV signed: a=-7, b=2 -> quotient=-3 (0xFFFF_FFFF_FFFF_FFFD), remainder=-1. Then a=7, b=-2 -> quotient=-3, remainder=1.
- DIVW overflow: a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF, signed, div_32=1 -> out_valid at T+1; quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- Divide by zero: DIVU a=0x1234, b=0 -> T+1: quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234. REMUW a=0x1_8000_0001, b=0 -> remainder=0xFFFF_FFFF_8000_0001.
- DIVUW: a=0xFFFF_FFFF, b=1 -> out_valid at T+33; quotient=0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Flush at T+10 of a 64-bit op -> no out_valid pulse, div_ready=1 at T+11. A new op accepted at T+11 then completes correctly. Separately, rst pulsed mid-CALC -> all outputs 0 and div_ready=1 immediately.
